// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the two-requester shared-adder arbiter.
package adder_arb_pkg;

   localparam int DATA_W   = 32;
   localparam int REQ_ID_W = 1;

   typedef logic [REQ_ID_W-1:0] req_id_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response handshake bundle between two requesters and the shared adder.
interface adder_arbiter_if;
   import adder_arb_pkg::*;

   logic              req0_valid;
   logic              req0_ready;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic              req1_valid;
   logic              req1_ready;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic              rsp0_valid;
   logic              rsp0_ready;
   logic              rsp1_valid;
   logic              rsp1_ready;
   logic [DATA_W-1:0] rsp_sum;
   logic              rsp_cout;

   modport master (
      output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
             rsp0_ready, rsp1_ready,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_sum, rsp_cout
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
             rsp0_ready, rsp1_ready,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_sum, rsp_cout
   );

endinterface

// File: rtl/adder_32_bit.sv
// Plain 32-bit unsigned adder, no carry-in; carry-out of bit 31 exposed separately.
module adder_32_bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum,
   output logic        cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_arbiter_rr.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module rr_arbiter_2
   import adder_arb_pkg::*;
(
   input  logic [1:0] req,
   input  req_id_t    last_grant,
   input  logic       en,
   output req_id_t    grant,
   output logic       gnt_valid
);

   always_comb begin
      grant = '0;
      case (req)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_grant;
         default: grant = '0;
      endcase
      gnt_valid = en & (|req);
   end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder between two requesters with round-robin grant and a single
// registered result slot that is returned only to the requester that issued it.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_EMPTY | no result held; a granted request is accepted this cycle
//   ST_FULL  | result held for owner_q; waits for that owner's rsp ready
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter bit RR_INIT = 1'b0,
   parameter bit SKID_EN = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   adder_arbiter_if.slave  bus
);

   state_t            state_q, state_d;
   req_id_t           owner_q, owner_d;
   req_id_t           last_grant_q, last_grant_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic              cout_q, cout_d;
   logic [DATA_W-1:0] op_a_q, op_a_d;
   logic [DATA_W-1:0] op_b_q, op_b_d;

   logic              owner_ready;
   logic              drain;
   logic              slot_free;
   req_id_t           grant;
   logic              gnt_valid;
   logic [DATA_W-1:0] add_sum;
   logic              add_cout;

   assign owner_ready = (owner_q == 1'b1) ? bus.rsp1_ready : bus.rsp0_ready;
   assign drain       = (state_q == ST_FULL) & owner_ready;
   assign slot_free   = (state_q == ST_EMPTY) | (drain & SKID_EN);

   // Ready is forced low while reset is asserted so nothing is handed over.
   rr_arbiter_2 u_rr (
      .req        ({bus.req1_valid, bus.req0_valid}),
      .last_grant (last_grant_q),
      .en         (slot_free & ~reset),
      .grant      (grant),
      .gnt_valid  (gnt_valid)
   );

   // Operands are only switched on an accept, so the adder inputs stay quiet otherwise.
   always_comb begin
      op_a_d = op_a_q;
      op_b_d = op_b_q;
      if (gnt_valid) begin
         op_a_d = (grant == 1'b1) ? bus.req1_a : bus.req0_a;
         op_b_d = (grant == 1'b1) ? bus.req1_b : bus.req0_b;
      end
   end

   adder_32_bit u_add (
      .a    (op_a_d),
      .b    (op_b_d),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      sum_d        = sum_q;
      cout_d       = cout_q;
      if (gnt_valid) begin
         state_d      = ST_FULL;
         owner_d      = grant;
         last_grant_d = grant;
         sum_d        = add_sum;
         cout_d       = add_cout;
      end else if (drain) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_EMPTY;
         owner_q      <= '0;
         last_grant_q <= req_id_t'(RR_INIT);
         sum_q        <= '0;
         cout_q       <= 1'b0;
         op_a_q       <= '0;
         op_b_q       <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         sum_q        <= sum_d;
         cout_q       <= cout_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
      end
   end

   assign bus.req0_ready = gnt_valid & (grant == 1'b0);
   assign bus.req1_ready = gnt_valid & (grant == 1'b1);
   assign bus.rsp0_valid = (state_q == ST_FULL) & (owner_q == 1'b0);
   assign bus.rsp1_valid = (state_q == ST_FULL) & (owner_q == 1'b1);
   assign bus.rsp_sum    = sum_q;
   assign bus.rsp_cout   = cout_q;

endmodule
